booth16_mul_ctrl: RTL and testbench

Sequencing controller for the sequential radix-16 Booth multiplier datapath.
- Accepts one multiplier operand per operation through a valid/ready handshake.
- Holds and scans the operand 4 bits per cycle, presenting each 5-bit Booth window and its decoded signed digit to the partial-product logic.
- Drives the step/first/last strobes that advance the partial-product shift register.
- Signals result completion through an output valid/ready handshake.

---
 rtl/booth16_pkg.sv | 19 +
 rtl/booth16_digit_dec.sv | 20 ++
 rtl/booth16_mul_ctrl.sv | 134 +++++++++++++
 tb/tb_booth16_mul_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth16_pkg.sv
// Shared types for the radix-16 Booth multiplier controller and its digit decoder.
package booth16_pkg;

    localparam int DIG_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [4:0] booth_win_t;

    typedef struct packed {
        logic       neg;
        logic [3:0] mag;
    } booth_digit_t;

endpackage

// File: rtl/booth16_digit_dec.sv
// Radix-16 Booth digit decoder: 5-bit window {b[4i+3:4i], b[4i-1]} to sign/magnitude digit.
module booth16_digit_dec
    import booth16_pkg::*;
(
    input  booth_win_t   win,
    output booth_digit_t digit
);

    logic signed [4:0] d;
    logic signed [4:0] d_abs;

    // win[4:1] read as a signed nibble is -8*w4 + 4*w3 + 2*w2 + w1; w0 adds the carry-in bit.
    always_comb begin
        d         = $signed({win[4], win[4:1]}) + $signed({4'b0000, win[0]});
        d_abs     = d[4] ? -d : d;
        digit.neg = d[4];
        digit.mag = d_abs[3:0];
    end

endmodule

// File: rtl/booth16_mul_ctrl.sv
// Sequencing controller for the sequential radix-16 Booth multiplier datapath.
// Optional BOOTH16_PERF_CNT_EN adds perf_ops / perf_stall counters.
module booth16_mul_ctrl
    import booth16_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mult_b,
    input  logic             flush,
    output logic             step_en,
    output logic             step_first,
    output logic             step_last,
    output logic [4:0]       booth_win,
    output logic             digit_neg,
    output logic [3:0]       digit_mag,
    output logic             out_valid,
    input  logic             out_ready
`ifdef BOOTH16_PERF_CNT_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
`endif
);

    localparam int NDIG  = WIDTH / DIG_BITS;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e             state_q, state_d;
    logic [WIDTH:0]     breg_q, breg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    booth_digit_t       digit;

    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        breg_d     = breg_q;
        cnt_d      = cnt_q;
        in_ready   = 1'b0;
        step_en    = 1'b0;
        step_first = 1'b0;
        step_last  = 1'b0;
        out_valid  = 1'b0;
        booth_win  = '0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    breg_d  = {mult_b, 1'b0};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_en    = 1'b1;
                booth_win  = breg_q[4:0];
                step_first = (cnt_q == '0);
                step_last  = (cnt_q == CNT_W'(NDIG - 1));
                breg_d     = {{DIG_BITS{breg_q[WIDTH]}}, breg_q[WIDTH:DIG_BITS]};
                cnt_d      = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (step_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            breg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            breg_q  <= breg_d;
            cnt_q   <= cnt_d;
        end
    end

    booth16_digit_dec u_dec (
        .win   (booth_win),
        .digit (digit)
    );

    assign digit_neg = digit.neg;
    assign digit_mag = digit.mag;

`ifdef BOOTH16_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // A flush cycle in DONE is neither a completion nor a stall.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (state_q == DONE && !flush) begin
            if (out_ready) perf_ops_d   = perf_ops_q + 32'd1;
            else           perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_booth16_mul_ctrl.sv
// Scoreboard bench for booth16_mul_ctrl (WIDTH=8 and WIDTH=16) and booth16_digit_dec.
module tb_booth16_mul_ctrl;
    import booth16_pkg::*;

    typedef struct {
        logic [4:0] win;
        logic       neg;
        logic [3:0] mag;
        logic       first;
        logic       last;
    } step_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    step_t step_q[$];
    int    done_q[$];

    // ---------------- WIDTH=8 instance ----------------
    logic       in_valid, in_ready, flush, out_valid, out_ready;
    logic [7:0] mult_b;
    logic       step_en, step_first, step_last, digit_neg;
    logic [4:0] booth_win;
    logic [3:0] digit_mag;
`ifdef BOOTH16_PERF_CNT_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    booth16_mul_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mult_b(mult_b), .flush(flush), .step_en(step_en), .step_first(step_first),
        .step_last(step_last), .booth_win(booth_win), .digit_neg(digit_neg),
        .digit_mag(digit_mag), .out_valid(out_valid), .out_ready(out_ready)
`ifdef BOOTH16_PERF_CNT_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    // ---------------- WIDTH=16 instance ----------------
    logic        rst16_n, in_valid16, in_ready16, out_valid16;
    logic [15:0] mult16;
    logic        step_en16, step_first16, step_last16, digit_neg16;
    logic [4:0]  booth_win16;
    logic [3:0]  digit_mag16;
`ifdef BOOTH16_PERF_CNT_EN
    logic [31:0] perf_ops16, perf_stall16;
`endif

    booth16_mul_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst16_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .mult_b(mult16), .flush(1'b0), .step_en(step_en16), .step_first(step_first16),
        .step_last(step_last16), .booth_win(booth_win16), .digit_neg(digit_neg16),
        .digit_mag(digit_mag16), .out_valid(out_valid16), .out_ready(1'b1)
`ifdef BOOTH16_PERF_CNT_EN
        , .perf_ops(perf_ops16), .perf_stall(perf_stall16)
`endif
    );

    // ---------------- standalone decoder ----------------
    booth_win_t   dec_win;
    booth_digit_t dec_digit;

    booth16_digit_dec u_dec_ref (
        .win   (dec_win),
        .digit (dec_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_step(input logic [4:0] win, input logic neg, input logic [3:0] mag,
                             input logic first, input logic last);
        step_t s;
        s.win = win; s.neg = neg; s.mag = mag; s.first = first; s.last = last;
        step_q.push_back(s);
    endtask

    // Two-digit WIDTH=8 operation with hand-decoded windows; completion after 2 steps.
    task automatic push_op8(input logic [4:0] w0, input logic n0, input logic [3:0] m0,
                            input logic [4:0] w1, input logic n1, input logic [3:0] m1);
        push_step(w0, n0, m0, 1'b1, 1'b0);
        push_step(w1, n1, m1, 1'b0, 1'b1);
        done_q.push_back(2);
    endtask

    task automatic accept8(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        mult_b   = b;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle8();
        int t;
        t = 0;
        while (!(in_ready && !out_valid && !step_en) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: compares every presented step and every completion against the queues.
    int   run_start = 0;
    int   nsteps    = 0;
    logic ov_prev   = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (step_en) begin
                step_t e;
                if (step_first) begin
                    run_start = cyc;
                    nsteps    = 0;
                end
                nsteps++;
                if (step_q.size() == 0) begin
                    check("step_unexpected", 32'd1, 32'd0);
                end else begin
                    e = step_q.pop_front();
                    check("step_win", 32'(booth_win), 32'(e.win));
                    check("step_digit", {digit_neg, digit_mag}, {e.neg, e.mag});
                    check("step_first_last", {step_first, step_last}, {e.first, e.last});
                end
            end else begin
                check("idle_win_zero", {booth_win, digit_neg, digit_mag}, 32'd0);
            end
            if (out_valid && !ov_prev) begin
                int exp_steps;
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_steps = done_q.pop_front();
                    check("done_nsteps", nsteps, exp_steps);
                    check("done_latency", cyc - run_start, exp_steps);
                    check("done_in_ready", 32'(in_ready), 32'd0);
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        int t;
        int n16;
`ifdef BOOTH16_PERF_CNT_EN
        logic [31:0] ops0, stall0;
`endif
        rst_n = 1'b0; rst16_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; mult_b = '0;
        in_valid16 = 1'b0; mult16 = '0; dec_win = '0;

        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_strobes", {step_en, step_first, step_last, out_valid}, 32'd0);
        check("rst_win_digit", {booth_win, digit_neg, digit_mag}, 32'd0);
        #10;
        rst_n = 1'b1; rst16_n = 1'b1;
        @(posedge clk); #1;

        // Exhaustive decoder sweep against the arithmetic formula.
        for (int w = 0; w < 32; w++) begin
            int d;
            logic [4:0] wb;
            wb      = 5'(w);
            dec_win = wb;
            #1;
            d = -8 * int'(wb[4]) + 4 * int'(wb[3]) + 2 * int'(wb[2]) + int'(wb[1]) + int'(wb[0]);
            check($sformatf("dec_%02h", w), {dec_digit.neg, dec_digit.mag},
                  {d < 0, 4'((d < 0) ? -d : d)});
        end

        // 0x7B: windows 10110 (-5), 01111 (+8).
        push_op8(5'b10110, 1'b1, 4'd5, 5'b01111, 1'b0, 4'd8);
        accept8(8'h7B);
        check("7b_cycle1_first", {step_en, step_first, step_last}, 3'b110);
        @(posedge clk); #1;
        check("7b_cycle2_last", {step_en, step_first, step_last}, 3'b101);
        @(posedge clk); #1;
        check("7b_cycle3_valid", {out_valid, step_en}, 2'b10);
        wait_idle8();

        // 0x80 then 0xFF, with in_valid held high while busy: second operand waits, is not lost.
        push_op8(5'b00000, 1'b0, 4'd0, 5'b10000, 1'b1, 4'd8);
        push_op8(5'b11110, 1'b1, 4'd1, 5'b11111, 1'b0, 4'd0);
        in_valid = 1'b1; mult_b = 8'h80;
        @(posedge clk); #1;
        mult_b = 8'hFF;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("held_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle8();

        // Back-pressure: out_ready low for 5 DONE cycles.
`ifdef BOOTH16_PERF_CNT_EN
        ops0 = perf_ops; stall0 = perf_stall;
`endif
        out_ready = 1'b0;
        push_op8(5'b00010, 1'b0, 4'd1, 5'b00000, 1'b0, 4'd0);
        accept8(8'h01);
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) check("stall_valid_timeout", 32'd1, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_hold_%0d", i), {out_valid, in_ready}, 2'b10);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release", {out_valid, in_ready}, 2'b01);
`ifdef BOOTH16_PERF_CNT_EN
        check("perf_stall_delta", perf_stall - stall0, 32'd5);
        check("perf_ops_delta", perf_ops - ops0, 32'd1);
`endif

        // Flush in RUN cycle 1: only the first step is seen, no completion.
        push_step(5'b10110, 1'b1, 4'd5, 1'b1, 1'b0);
        accept8(8'h7B);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", {in_ready, step_en, step_last, out_valid}, 4'b1000);
        @(posedge clk); #1;
        check("flush_stays_idle", {in_ready, step_en, out_valid}, 3'b100);
        // 0x35: windows 01010 (+5), 00110 (+3).
        push_op8(5'b01010, 1'b0, 4'd5, 5'b00110, 1'b0, 4'd3);
        accept8(8'h35);
        wait_idle8();

        // Flush in IDLE suppresses a same-cycle accept.
        in_valid = 1'b1; flush = 1'b1; mult_b = 8'h55;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_no_accept", {in_ready, step_en}, 2'b10);

        // WIDTH=16: asynchronous reset in the middle of RUN.
        in_valid16 = 1'b1; mult16 = 16'h8001;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        @(posedge clk); #1;
        check("w16_running", {step_en16, in_ready16}, 2'b10);
        #2;
        rst16_n = 1'b0;
        #1;
        check("w16_rst_in_ready", 32'(in_ready16), 32'd1);
        check("w16_rst_strobes", {step_en16, step_first16, step_last16, out_valid16}, 32'd0);
        check("w16_rst_win", {booth_win16, digit_neg16, digit_mag16}, 32'd0);
        @(posedge clk); #1;
        rst16_n = 1'b1;
        @(posedge clk); #1;
        check("w16_after_rst", {in_ready16, step_en16, out_valid16}, 3'b100);
        // Fresh operation runs exactly 4 steps; first window of 0x8001 is 00010 (+1).
        in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        check("w16_first_win", {booth_win16, digit_neg16, digit_mag16, step_first16}, {5'b00010, 1'b0, 4'd1, 1'b1});
        n16 = 0;
        t   = 0;
        while (!out_valid16 && t < 20) begin
            if (step_en16) n16++;
            @(posedge clk); #1;
            t++;
        end
        check("w16_nsteps", n16, 4);

        repeat (4) @(posedge clk);
        #1;
        check("step_queue_empty", step_q.size(), 0);
        check("done_queue_empty", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
